// File: rtl/mips_test_harness.sv
// Load-and-run harness for the MIPS core: streams a program into instruction
// memory, releases the core, then reports pass/fail/timeout on halt.
module mips_test_harness #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 10,
  parameter int N_WORDS   = 16,
  parameter int BYTE_ADDR = 1,
  parameter int TIMEOUT   = 1024,
  parameter int CNT_W     = $clog2(TIMEOUT + 1)
) (
  input  logic              clk_CPU,
  input  logic              rst,
  input  logic              start,
  input  logic              prog_valid,
  input  logic [DATA_W-1:0] prog_data,
  output logic              prog_ready,
  output logic              im_we,
  output logic [ADDR_W-1:0] im_addr,
  output logic [DATA_W-1:0] im_wdata,
  output logic              cpu_rst,
  input  logic              halt,
  input  logic [DATA_W-1:0] resultado,
  input  logic [DATA_W-1:0] expected,
  output logic [CNT_W-1:0]  cycles,
  output logic              done,
  output logic              pass,
  output logic              fail,
  output logic              timeout
);

  localparam int K_W = ADDR_W + 1;

  typedef enum logic [2:0] {
    IDLE, LOAD, RUN, ST_PASS, ST_FAIL, ST_TMO
  } state_t;

  state_t             state, state_n;
  logic [K_W-1:0]     k, k_n;
  logic [ADDR_W-1:0]  kw, addr_n;
  logic [DATA_W-1:0]  wdata_n;
  logic [CNT_W-1:0]   cyc_n;
  logic               we_n, done_n, pass_n, fail_n, tmo_n;
  logic               hs, k_full;

  assign k_full     = (k >= K_W'(N_WORDS));
  assign prog_ready = (state == LOAD) && !k_full;
  assign hs         = prog_valid && prog_ready;
  assign kw         = k[ADDR_W-1:0];

  always_comb begin
    state_n = state;
    k_n     = k;
    we_n    = 1'b0;
    addr_n  = im_addr;
    wdata_n = im_wdata;
    cyc_n   = cycles;
    done_n  = done;
    pass_n  = pass;
    fail_n  = fail;
    tmo_n   = timeout;
    unique case (state)
      IDLE, ST_PASS, ST_FAIL, ST_TMO: begin
        if (start) begin
          state_n = LOAD;
          k_n     = '0;
          cyc_n   = '0;
          done_n  = 1'b0;
          pass_n  = 1'b0;
          fail_n  = 1'b0;
          tmo_n   = 1'b0;
        end
      end
      LOAD: begin
        if (hs) begin
          we_n    = 1'b1;
          addr_n  = (BYTE_ADDR != 0) ? (kw << 2) : kw;
          wdata_n = prog_data;
          k_n     = k + K_W'(1);
        end else if (k_full) begin
          // Last write was issued last cycle; release the core now.
          state_n = RUN;
        end
      end
      RUN: begin
        if (halt) begin
          done_n  = 1'b1;
          if (resultado == expected) begin
            pass_n  = 1'b1;
            state_n = ST_PASS;
          end else begin
            fail_n  = 1'b1;
            state_n = ST_FAIL;
          end
        end else if (cycles == CNT_W'(TIMEOUT - 1)) begin
          done_n  = 1'b1;
          tmo_n   = 1'b1;
          state_n = ST_TMO;
        end else begin
          cyc_n = cycles + CNT_W'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk_CPU or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      k        <= '0;
      im_we    <= 1'b0;
      im_addr  <= '0;
      im_wdata <= '0;
      cpu_rst  <= 1'b1;
      cycles   <= '0;
      done     <= 1'b0;
      pass     <= 1'b0;
      fail     <= 1'b0;
      timeout  <= 1'b0;
    end else begin
      state    <= state_n;
      k        <= k_n;
      im_we    <= we_n;
      im_addr  <= addr_n;
      im_wdata <= wdata_n;
      cpu_rst  <= (state_n != RUN);
      cycles   <= cyc_n;
      done     <= done_n;
      pass     <= pass_n;
      fail     <= fail_n;
      timeout  <= tmo_n;
    end
  end

endmodule

// File: doc/mips_test_harness.md
Name: mips_test_harness

Overview:
Synthesizable, parametrised successor to the CPU bench harness. It streams a program into the CPU instruction memory, then releases the CPU from reset and counts execution cycles. When the CPU signals halt, it compares `resultado` against an expected value and reports pass, fail or timeout. It sits between a program source (UART loader or bench) and the MIPS core, replacing file-based memory preload.

Parameters:
- DATA_W, 32, width of program words, `resultado` and `expected`
- ADDR_W, 10, instruction-memory write-address width
- N_WORDS, 16, number of program words loaded per run (1..2**ADDR_W)
- BYTE_ADDR, 1, 1 = `im_addr` is a byte address (k<<2); 0 = word index k
- TIMEOUT, 1024, maximum RUN cycles before timeout (≥2)
- CNT_W, $clog2(TIMEOUT+1), width of the cycle counter

Ports:
- clk_CPU  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  begin a load-and-run sequence; one-cycle pulse or level
- prog_valid  in  1  program word available
- prog_data  in  DATA_W  program word
- prog_ready  out  1  harness accepts a word this cycle
- im_we  out  1  instruction-memory write enable
- im_addr  out  ADDR_W  instruction-memory write address
- im_wdata  out  DATA_W  instruction-memory write data
- cpu_rst  out  1  reset held on the MIPS core
- halt  in  1  CPU reached its end-of-program condition
- resultado  in  DATA_W  CPU result bus
- expected  in  DATA_W  golden result; sampled at halt
- cycles  out  CNT_W  RUN cycles counted (frozen after RUN ends)
- done  out  1  terminal state reached
- pass  out  1  halt seen with `resultado` == `expected`
- fail  out  1  halt seen with a mismatch
- timeout  out  1  TIMEOUT cycles elapsed without halt

Behaviour:
- **Reset values (async, while `rst`=1):**
  - state = IDLE
  - `cpu_rst` = 1
  - `prog_ready`, `im_we`, `done`, `pass`, `fail`, `timeout` = 0
  - `im_addr`, `im_wdata`, `cycles` = 0
  - word counter k = 0
  - Reset mid-LOAD or mid-RUN aborts immediately; no partial status is retained.
- **IDLE:**
  - `prog_ready`=0, `cpu_rst`=1.
  - `start`=1 → LOAD next cycle; k, `cycles` and all status flags are cleared.
- **LOAD:**
  - `prog_ready`=1 while k < N_WORDS; `cpu_rst`=1.
  - Handshake occurs when `prog_valid` && `prog_ready`.
  - A handshake in cycle t produces, in cycle t+1 (registered): `im_we`=1, `im_wdata`=the word, `im_addr` = BYTE_ADDR ? k<<2 : k. k then increments.
  - `im_we`=0 in any cycle following a non-handshake cycle. Gaps in `prog_valid` are allowed.
  - `prog_ready` drops combinationally once k == N_WORDS, so no extra word is accepted.
  - `im_addr` is truncated to ADDR_W bits.
  - The state moves to RUN in the cycle after the last `im_we` pulse, so the write completes before `cpu_rst` deasserts.
- **RUN:**
  - `cpu_rst`=0. `cycles` increments by 1 each RUN cycle, starting from 0.
  - `halt`=1 → `resultado` and `expected` are compared that cycle; next state is PASS or FAIL.
  - If `cycles` == TIMEOUT-1 and `halt`=0 → TIMEOUT state.
  - If `halt` and the timeout condition occur in the same cycle, halt wins.
  - `halt` is ignored outside RUN.
- **PASS / FAIL / TIMEOUT (terminal):**
  - `cpu_rst`=1 and `done`=1; exactly one of `pass`/`fail`/`timeout` is 1, and it stays set.
  - `cycles` holds its final value.
  - `start`=1 → LOAD (restart; flags cleared on entry).
- `start` is ignored in LOAD and RUN.
- Latency from the final handshake to `cpu_rst` falling is 2 cycles.
- All outputs are registered except `prog_ready`, which is decoded from the state and k.

Test Plan:
1. Reset, `start` pulse, 16 back-to-back words 0x20080005.. with `prog_valid`=1 held → 16 consecutive `im_we` pulses, `im_addr` 0x000,0x004,..,0x03C, `prog_ready` low after the 16th; `cpu_rst` falls 2 cycles after the last handshake.
2. Load with `prog_valid` toggled every other cycle → `im_we` pulses only after accepted words, addresses contiguous with no skips and no 17th write.
3. RUN, `halt` at cycle 10, `resultado`=`expected`=0x0000000F → `pass`=1, `done`=1, `cycles`=10, `cpu_rst`=1.
4. `halt` with `resultado`=0x0E, `expected`=0x0F → `fail`=1, `pass`=0; then a second `start` → flags clear, LOAD re-entered at k=0.
5. TIMEOUT=8, no `halt` → `timeout`=1 after 8 RUN cycles, `cycles`=7; variant with `halt` exactly at `cycles`=7 → `pass`/`fail`, not `timeout`.
6. Assert `rst` mid-RUN and mid-LOAD → all outputs at reset values in the same cycle, `cpu_rst`=1, state IDLE.
